// File: rtl/video_flow_pkg.sv
// rtl/video_flow_pkg.sv - shared constants, FSM states and window helper for the flow sampler
package video_flow_pkg;

  localparam logic [2:0] ADDR_SCR        = 3'd0;
  localparam logic [2:0] ADDR_FLOWLENGTH = 3'd1;
  localparam logic [2:0] ADDR_WIN_X      = 3'd2;
  localparam logic [2:0] ADDR_WIN_Y      = 3'd3;
  localparam logic [2:0] ADDR_LINES      = 3'd4;
  localparam logic [2:0] ADDR_PIXELS     = 3'd5;
  localparam logic [2:0] ADDR_DROPPED    = 3'd6;
  localparam logic [2:0] ADDR_FRAMES     = 3'd7;

  localparam int SCR_ENABLE_BIT = 0;
  localparam int SCR_SINGLE_BIT = 1;
  localparam int SCR_SKIP_LSB   = 8;
  localparam int SCR_SKIP_MSB   = 15;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    SKIP,
    CAPTURE,
    TAIL
  } state_t;

  // 17-bit difference: a position below start sets bit 16, so it never lands inside the window.
  function automatic logic in_range(input logic [15:0] pos, input logic [15:0] start,
                                    input logic [15:0] len);
    logic [16:0] diff;
    diff = {1'b0, pos} - {1'b0, start};
    if (len == 16'd0) return ~diff[16];
    return diff < {1'b0, len};
  endfunction

endpackage

// File: rtl/video_flow_regs.sv
// rtl/video_flow_regs.sv - Avalon-MM register file: control, window, read mux, single-shot clear
module video_flow_regs
  import video_flow_pkg::*;
#(
  parameter int          DATA_WIDTH         = 32,
  parameter int unsigned DEFAULT_SCR        = 0,
  parameter int unsigned DEFAULT_FLOWLENGTH = 512*512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  clr_enable,
  input  logic [DATA_WIDTH-1:0] lines,
  input  logic [DATA_WIDTH-1:0] pixels,
  input  logic [DATA_WIDTH-1:0] dropped,
  input  logic [DATA_WIDTH-1:0] frames,
  output logic                  enable,
  output logic                  single_shot,
  output logic [7:0]            skip,
  output logic [DATA_WIDTH-1:0] flowlength,
  output logic [15:0]           win_x_start,
  output logic [15:0]           win_x_len,
  output logic [15:0]           win_y_start,
  output logic [15:0]           win_y_len,
  output logic [DATA_WIDTH-1:0] readdata
);

  localparam logic [DATA_WIDTH-1:0] SCR_MASK = DATA_WIDTH'(32'h0000_ff03);

  logic [DATA_WIDTH-1:0] scr, win_x, win_y, rd_mux;

  assign enable      = scr[SCR_ENABLE_BIT];
  assign single_shot = scr[SCR_SINGLE_BIT];
  assign skip        = scr[SCR_SKIP_MSB:SCR_SKIP_LSB];
  assign win_x_start = win_x[15:0];
  assign win_x_len   = win_x[31:16];
  assign win_y_start = win_y[15:0];
  assign win_y_len   = win_y[31:16];

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_SCR:        rd_mux = scr;
      ADDR_FLOWLENGTH: rd_mux = flowlength;
      ADDR_WIN_X:      rd_mux = win_x;
      ADDR_WIN_Y:      rd_mux = win_y;
      ADDR_LINES:      rd_mux = lines;
      ADDR_PIXELS:     rd_mux = pixels;
      ADDR_DROPPED:    rd_mux = dropped;
      ADDR_FRAMES:     rd_mux = frames;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scr        <= DATA_WIDTH'(DEFAULT_SCR) & SCR_MASK;
      flowlength <= DATA_WIDTH'(DEFAULT_FLOWLENGTH);
      win_x      <= '0;
      win_y      <= '0;
      readdata   <= '0;
    end else begin
      if (clr_enable) scr[SCR_ENABLE_BIT] <= 1'b0;
      // Placed after the clear so a same-cycle host write to SCR takes priority.
      if (write) begin
        case (address)
          ADDR_SCR:        scr        <= writedata & SCR_MASK;
          ADDR_FLOWLENGTH: flowlength <= writedata;
          ADDR_WIN_X:      win_x      <= writedata;
          ADDR_WIN_Y:      win_y      <= writedata;
          default:         ;
        endcase
      end
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/video_flow_sampler.sv
// rtl/video_flow_sampler.sv - camera window cropper emitting FLOWLENGTH-pixel flows per captured frame
module video_flow_sampler
  import video_flow_pkg::*;
#(
  parameter int          PIXEL_WIDTH        = 8,
  parameter int          CHANNELS           = 1,
  parameter int          DATA_WIDTH         = 32,
  parameter int unsigned DEFAULT_SCR        = 0,
  parameter int unsigned DEFAULT_FLOWLENGTH = 512*512
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            pix_en_i,
  input  logic                            href_i,
  input  logic                            vsync_i,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0] pixel_i,
  input  logic [2:0]                      address_i,
  input  logic                            write_i,
  input  logic                            read_i,
  input  logic [DATA_WIDTH-1:0]           writedata_i,
  output logic [DATA_WIDTH-1:0]           readdata_o,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] data_o,
  output logic                            dv_o,
  output logic                            fv_o
);

  localparam int PW = CHANNELS * PIXEL_WIDTH;

  logic          pix_en_s1, href_s1, href_s2, vsync_s1, vsync_s2;
  logic [PW-1:0] pixel_s1;
  logic [1:0]    live;
  logic          href_rise, href_fall, vsync_rise, vsync_fall;

  logic                  enable, single_shot;
  logic [7:0]            skip;
  logic [DATA_WIDTH-1:0] flowlength;
  logic [15:0]           win_x_start, win_x_len, win_y_start, win_y_len;

  state_t                state;
  logic [7:0]            skip_cnt;
  logic [DATA_WIDTH-1:0] sent, sent_next;
  logic [15:0]           x_cnt, y_cnt, cur_x, cur_y;
  logic [DATA_WIDTH-1:0] lines, pixels, dropped, frames;
  logic                  pix_valid, in_win, emit, capturing, clr_enable;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  video_flow_regs #(
    .DATA_WIDTH        (DATA_WIDTH),
    .DEFAULT_SCR       (DEFAULT_SCR),
    .DEFAULT_FLOWLENGTH(DEFAULT_FLOWLENGTH)
  ) u_regs (
    .clk        (clk_i),
    .reset      (reset_i),
    .address    (address_i),
    .write      (write_i),
    .read       (read_i),
    .writedata  (writedata_i),
    .clr_enable (clr_enable),
    .lines      (lines),
    .pixels     (pixels),
    .dropped    (dropped),
    .frames     (frames),
    .enable     (enable),
    .single_shot(single_shot),
    .skip       (skip),
    .flowlength (flowlength),
    .win_x_start(win_x_start),
    .win_x_len  (win_x_len),
    .win_y_start(win_y_start),
    .win_y_len  (win_y_len),
    .readdata   (readdata_o)
  );

  // live[1] marks both stages as holding real samples, so a level held across reset is not an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pix_en_s1 <= 1'b0;
      href_s1   <= 1'b0;
      href_s2   <= 1'b0;
      vsync_s1  <= 1'b0;
      vsync_s2  <= 1'b0;
      pixel_s1  <= '0;
      live      <= 2'b00;
    end else begin
      pix_en_s1 <= pix_en_i;
      href_s1   <= href_i;
      href_s2   <= href_s1;
      vsync_s1  <= vsync_i;
      vsync_s2  <= vsync_s1;
      pixel_s1  <= pixel_i;
      live      <= {live[0], 1'b1};
    end
  end

  assign href_rise  = live[1] &  href_s1  & ~href_s2;
  assign href_fall  = live[1] & ~href_s1  &  href_s2;
  assign vsync_rise = live[1] &  vsync_s1 & ~vsync_s2;
  assign vsync_fall = live[1] & ~vsync_s1 &  vsync_s2;

  assign cur_x     = href_rise  ? 16'd0 : x_cnt;
  assign cur_y     = vsync_rise ? 16'd0 : y_cnt;
  assign pix_valid = pix_en_s1 & href_s1;
  assign in_win    = pix_valid & in_range(cur_x, win_x_start, win_x_len)
                               & in_range(cur_y, win_y_start, win_y_len);
  assign capturing = (state == CAPTURE) || (state == TAIL);
  assign emit      = enable & (state == CAPTURE) & in_win & (sent != flowlength);
  assign sent_next = sent + DATA_WIDTH'(1);
  assign clr_enable = enable & single_shot & capturing & vsync_fall;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      skip_cnt <= '0;
      sent     <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      lines    <= '0;
      pixels   <= '0;
      dropped  <= '0;
      frames   <= '0;
      data_o   <= '0;
      dv_o     <= 1'b0;
      fv_o     <= 1'b0;
    end else begin
      if (href_rise)  x_cnt <= '0;
      if (pix_valid)  x_cnt <= cur_x + 16'd1;
      if (vsync_rise) y_cnt <= '0;
      if (href_fall)  y_cnt <= cur_y + 16'd1;

      dv_o <= emit;
      if (emit) data_o <= pixel_s1;
      // Flow stays open through line gaps; it closes on the last beat, a frame end or disable.
      fv_o <= emit | (fv_o & enable & (state == CAPTURE) & ~vsync_fall);

      if (enable && capturing) begin
        if (href_fall)       lines   <= sat_inc(lines);
        if (in_win)          pixels  <= sat_inc(pixels);
        if (in_win && !emit) dropped <= sat_inc(dropped);
      end

      if (!enable) begin
        state    <= IDLE;
        skip_cnt <= skip;
        if (capturing) frames <= sat_inc(frames);
      end else begin
        case (state)
          IDLE: begin
            state    <= WAIT_START;
            skip_cnt <= skip;
          end
          WAIT_START: begin
            if (vsync_rise) begin
              if (skip_cnt != 8'd0) begin
                state <= SKIP;
              end else begin
                state    <= (flowlength == '0) ? TAIL : CAPTURE;
                skip_cnt <= skip;
                sent     <= '0;
                lines    <= '0;
                pixels   <= '0;
                dropped  <= '0;
              end
            end
          end
          SKIP: begin
            if (vsync_fall) begin
              skip_cnt <= skip_cnt - 8'd1;
              state    <= WAIT_START;
            end
          end
          CAPTURE: begin
            if (emit) sent <= sent_next;
            if (vsync_fall) begin
              state  <= WAIT_START;
              frames <= sat_inc(frames);
            end else if ((emit && sent_next == flowlength) || sent == flowlength) begin
              state <= TAIL;
            end
          end
          TAIL: begin
            if (vsync_fall) begin
              state  <= WAIT_START;
              frames <= sat_inc(frames);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_flow_sampler.sv
// tb/tb_video_flow_sampler.sv - randomized self-checking bench for video_flow_sampler
module tb_video_flow_sampler;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        pix_en_i = 1'b0, href_i = 1'b0, vsync_i = 1'b0;
  logic [7:0]  pixel_i = '0;
  logic [2:0]  address_i = '0;
  logic        write_i = 1'b0, read_i = 1'b0;
  logic [31:0] writedata_i = '0;
  logic [31:0] readdata_o;
  logic [7:0]  data_o;
  logic        dv_o, fv_o;

  always #5 clk = ~clk;

  video_flow_sampler #(
    .PIXEL_WIDTH(8), .CHANNELS(1), .DATA_WIDTH(32),
    .DEFAULT_SCR(0), .DEFAULT_FLOWLENGTH(512*512)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pix_en_i(pix_en_i), .href_i(href_i), .vsync_i(vsync_i),
    .pixel_i(pixel_i), .address_i(address_i), .write_i(write_i), .read_i(read_i),
    .writedata_i(writedata_i), .readdata_o(readdata_o), .data_o(data_o), .dv_o(dv_o), .fv_o(fv_o)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int fv_cycles, fv_rises, fv_fall_cyc, dv_no_fv, first_dv_cyc, last_dv_cyc, vfall_cyc;
  logic fv_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (dv_o) begin
      got.push_back(data_o);
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      last_dv_cyc = cyc;
      if (!fv_o) dv_no_fv++;
    end
    if (fv_o) fv_cycles++;
    if (fv_o && !fv_prev) fv_rises++;
    if (!fv_o && fv_prev) fv_fall_cyc = cyc;
    fv_prev = fv_o;
  end

  int fw, fh;
  logic [7:0] fvals[$];
  logic [7:0] exp_q[$];
  int exp_inwin;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_mon();
    got.delete();
    fv_cycles = 0; fv_rises = 0; fv_fall_cyc = -1; dv_no_fv = 0;
    first_dv_cyc = -1; last_dv_cyc = -1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    address_i = a; writedata_i = d; write_i = 1'b1; tick(1); write_i = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    address_i = a; read_i = 1'b1; tick(1); read_i = 1'b0; d = readdata_o;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; tick(2); reset_i = 1'b0; tick(2);
  endtask

  task automatic cfg(input logic [31:0] scr, input int fl, input int sx, input int wx,
                     input int sy, input int wy);
    write_reg(3'd1, 32'(fl));
    write_reg(3'd2, {16'(wx), 16'(sx)});
    write_reg(3'd3, {16'(wy), 16'(sy)});
    write_reg(3'd0, scr);
  endtask

  task automatic build_frame(input int w, input int h, input bit rnd);
    fvals.delete(); fw = w; fh = h;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        fvals.push_back(rnd ? 8'($urandom) : 8'(y * w + x));
  endtask

  task automatic frame_open();
    vsync_i = 1'b1; tick(3);
  endtask

  task automatic frame_pixels(input int from, input int to);
    for (int k = from; k < to; k++) begin
      if (k % fw == 0) begin href_i = 1'b1; tick(1); end
      pix_en_i = 1'b1; pixel_i = fvals[k]; tick(1); pix_en_i = 1'b0;
      tick($urandom_range(0, 2));
      if (k % fw == fw - 1) begin href_i = 1'b0; tick(3); end
    end
  endtask

  task automatic frame_close();
    vsync_i = 1'b0; vfall_cyc = cyc; tick(8);
  endtask

  task automatic run_frame();
    frame_open(); frame_pixels(0, fw * fh); frame_close();
  endtask

  function automatic bit in_span(input int p, input int s, input int l);
    return (l == 0) ? (p >= s) : (p >= s && p < s + l);
  endfunction

  // Raster-order list of in-window pixels, truncated to the flow length.
  task automatic model(input int sx, input int wx, input int sy, input int wy, input int fl);
    exp_q.delete(); exp_inwin = 0;
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++)
        if (in_span(x, sx, wx) && in_span(y, sy, wy)) begin
          exp_inwin++;
          if (exp_q.size() < fl) exp_q.push_back(fvals[y * fw + x]);
        end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_i = 1'b1; tick(2);
    checks++;
    if ({dv_o, fv_o, data_o, readdata_o} !== 42'd0) begin
      errors++; $display("FAIL reset_outputs: got dv=%b fv=%b data=%h rd=%h required all 0", dv_o, fv_o, data_o, readdata_o);
    end
    reset_i = 1'b0; tick(2);
    read_reg(3'd0, r); checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_scr: got %h required 0", r); end
    read_reg(3'd1, r); checks++;
    if (r !== 32'd262144) begin errors++; $display("FAIL reset_flowlength: got %0d required 262144", r); end
    read_reg(3'd7, r); checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_frames: got %0d required 0", r); end
  endtask

  task automatic test_full_frame();
    logic [31:0] r; int bad;
    do_reset(); cfg(32'h1, 16, 0, 0, 0, 0);
    build_frame(4, 4, 0); model(0, 0, 0, 0, 16); clear_mon(); run_frame();
    bad = 0;
    for (int i = 0; i < 16; i++) if (i >= got.size() || got[i] !== 8'(i)) bad++;
    checks++;
    if (got.size() != 16 || bad != 0) begin errors++; $display("FAIL full_data: got %0d beats (%0d wrong) required 16 beats 0..15", got.size(), bad); end
    checks++;
    if (fv_rises != 1 || dv_no_fv != 0 || fv_cycles != last_dv_cyc - first_dv_cyc + 1 || fv_fall_cyc != last_dv_cyc + 1) begin
      errors++; $display("FAIL full_fv: got rises=%0d fv_cycles=%0d fall=%0d required 1 rise, %0d cycles, fall at %0d",
                         fv_rises, fv_cycles, fv_fall_cyc, last_dv_cyc - first_dv_cyc + 1, last_dv_cyc + 1);
    end
    read_reg(3'd7, r); checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL full_frames: got %0d required 1", r); end
    read_reg(3'd4, r); checks++;
    if (r !== 32'd4) begin errors++; $display("FAIL full_lines: got %0d required 4", r); end
  endtask

  task automatic test_window();
    logic [7:0] lit[6];
    logic [31:0] r; int bad;
    lit = '{8'd8, 8'd9, 8'd10, 8'd14, 8'd15, 8'd16};
    do_reset(); cfg(32'h1, 100, 2, 3, 1, 2);
    build_frame(6, 6, 0); clear_mon(); run_frame();
    bad = 0;
    for (int i = 0; i < 6; i++) if (i >= got.size() || got[i] !== lit[i]) bad++;
    checks++;
    if (got.size() != 6 || bad != 0) begin errors++; $display("FAIL window_data: got %0d beats (%0d wrong) required 8,9,10,14,15,16", got.size(), bad); end
    read_reg(3'd5, r); checks++;
    if (r !== 32'd6) begin errors++; $display("FAIL window_pixels: got %0d required 6", r); end
  endtask

  task automatic test_over_length();
    logic [31:0] r; int bad;
    do_reset(); cfg(32'h1, 10, 0, 0, 0, 0);
    build_frame(4, 4, 0); clear_mon(); run_frame();
    bad = 0;
    for (int i = 0; i < 10; i++) if (i >= got.size() || got[i] !== 8'(i)) bad++;
    checks++;
    if (got.size() != 10 || bad != 0) begin errors++; $display("FAIL over_data: got %0d beats (%0d wrong) required 10 beats 0..9", got.size(), bad); end
    checks++;
    if (fv_fall_cyc != last_dv_cyc + 1 || fv_cycles != last_dv_cyc - first_dv_cyc + 1 || fv_o !== 1'b0) begin
      errors++; $display("FAIL over_fv: got fall=%0d cycles=%0d required fall=%0d cycles=%0d", fv_fall_cyc, fv_cycles, last_dv_cyc + 1, last_dv_cyc - first_dv_cyc + 1);
    end
    read_reg(3'd6, r); checks++;
    if (r !== 32'd6) begin errors++; $display("FAIL over_dropped: got %0d required 6", r); end
  endtask

  task automatic test_short_frame();
    logic [31:0] r;
    do_reset(); cfg(32'h1, 20, 0, 0, 0, 0);
    build_frame(4, 3, 0);
    for (int f = 0; f < 2; f++) begin
      clear_mon(); run_frame();
      checks++;
      if (got.size() != 12 || got[0] !== 8'd0 || got[11] !== 8'd11 || fv_rises != 1) begin
        errors++; $display("FAIL short_data%0d: got %0d beats, %0d fv rises required 12 beats 0..11, 1 rise", f, got.size(), fv_rises);
      end
      // vsync is driven 2 ticks after a cycle boundary; the sampling edge plus 2 cycles puts the fall 3 negedges later.
      checks++;
      if (fv_fall_cyc != vfall_cyc + 3) begin
        errors++; $display("FAIL short_fv%0d: got fv fall at %0d required %0d", f, fv_fall_cyc, vfall_cyc + 3);
      end
    end
    read_reg(3'd7, r); checks++;
    if (r !== 32'd2) begin errors++; $display("FAIL short_frames: got %0d required 2", r); end
  endtask

  task automatic test_skip_single();
    logic [31:0] r;
    do_reset(); cfg(32'h0000_0203, 16, 0, 0, 0, 0);
    build_frame(4, 4, 0);
    clear_mon(); run_frame(); run_frame();
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL skip_ignored: got %0d beats required 0", got.size()); end
    clear_mon(); run_frame();
    checks++;
    if (got.size() != 16 || got[0] !== 8'd0 || got[15] !== 8'd15) begin errors++; $display("FAIL skip_captured: got %0d beats required 16", got.size()); end
    read_reg(3'd0, r); checks++;
    if (r !== 32'h0000_0202) begin errors++; $display("FAIL single_clear: got SCR %h required 00000202", r); end
    clear_mon(); run_frame();
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL single_after: got %0d beats required 0", got.size()); end
    read_reg(3'd7, r); checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL skip_frames: got %0d required 1", r); end
  endtask

  task automatic test_disable_mid();
    int bad;
    do_reset(); cfg(32'h1, 16, 0, 0, 0, 0);
    build_frame(4, 4, 0); clear_mon();
    frame_open(); frame_pixels(0, 5);
    write_reg(3'd0, 32'h0); tick(1);
    checks++;
    if (fv_o !== 1'b0 || dv_o !== 1'b0) begin errors++; $display("FAIL disable_out: got fv=%b dv=%b required 0 0", fv_o, dv_o); end
    frame_pixels(5, 16); frame_close();
    bad = 0;
    for (int i = 0; i < 5; i++) if (i >= got.size() || got[i] !== 8'(i)) bad++;
    checks++;
    if (got.size() != 5 || bad != 0) begin errors++; $display("FAIL disable_data: got %0d beats (%0d wrong) required 5 beats 0..4", got.size(), bad); end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    do_reset(); cfg(32'h1, 16, 0, 0, 0, 0);
    build_frame(4, 4, 0); clear_mon();
    frame_open(); frame_pixels(0, 5);
    reset_i = 1'b1; tick(1); reset_i = 1'b0;
    checks++;
    if ({dv_o, fv_o, data_o, readdata_o} !== 42'd0) begin
      errors++; $display("FAIL reset_mid_out: got dv=%b fv=%b data=%h rd=%h required all 0", dv_o, fv_o, data_o, readdata_o);
    end
    n = got.size();
    cfg(32'h1, 16, 0, 0, 0, 0);
    frame_pixels(5, 16); frame_close();
    checks++;
    if (got.size() != n) begin errors++; $display("FAIL reset_mid_quiet: got %0d beats required %0d", got.size(), n); end
    clear_mon(); run_frame();
    bad = 0;
    for (int i = 0; i < 16; i++) if (i >= got.size() || got[i] !== 8'(i)) bad++;
    checks++;
    if (got.size() != 16 || bad != 0) begin errors++; $display("FAIL reset_mid_resume: got %0d beats (%0d wrong) required 16", got.size(), bad); end
  endtask

  task automatic test_random();
    int w, h, sx, wx, sy, wy, fl, bad;
    logic [31:0] r;
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 7); h = $urandom_range(1, 6);
      sx = $urandom_range(0, w); wx = $urandom_range(0, w);
      sy = $urandom_range(0, h); wy = $urandom_range(0, h);
      fl = (it == 0) ? 0 : $urandom_range(0, w * h + 2);
      do_reset(); cfg(32'h1, fl, sx, wx, sy, wy);
      build_frame(w, h, 1); model(sx, wx, sy, wy, fl); clear_mon(); run_frame();
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
      checks++;
      if (got.size() != exp_q.size() || bad != 0 || dv_no_fv != 0) begin
        errors++; $display("FAIL rand%0d_data: got %0d beats (%0d wrong, %0d without fv) required %0d", it, got.size(), bad, dv_no_fv, exp_q.size());
      end
      read_reg(3'd5, r); checks++;
      if (r !== 32'(exp_inwin)) begin errors++; $display("FAIL rand%0d_pixels: got %0d required %0d", it, r, exp_inwin); end
      read_reg(3'd6, r); checks++;
      if (r !== 32'(exp_inwin - exp_q.size())) begin errors++; $display("FAIL rand%0d_dropped: got %0d required %0d", it, r, exp_inwin - exp_q.size()); end
      read_reg(3'd4, r); checks++;
      if (r !== 32'(h)) begin errors++; $display("FAIL rand%0d_lines: got %0d required %0d", it, r, h); end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_frame();
    test_window();
    test_over_length();
    test_short_frame();
    test_skip_single();
    test_disable_mid();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
